// File: rtl/traffic_pkg.sv
// Shared phase encoding and timer width for the traffic phase sequencer.
package traffic_pkg;

   localparam int DUR_W = 8;

   typedef enum logic [2:0] {
      PH_NSG = 3'd0,
      PH_NSY = 3'd1,
      PH_AR1 = 3'd2,
      PH_EWG = 3'd3,
      PH_EWY = 3'd4,
      PH_AR2 = 3'd5,
      PH_PED = 3'd6,
      PH_EMG = 3'd7
   } phase_t;

endpackage

// File: rtl/traffic_phase_seq_timer.sv
// phase_timer: counts tick strobes within a phase and flags the expiring tick.
module phase_timer
   import traffic_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             clr,
   input  logic [DUR_W-1:0] dur,
   output logic             tc
);

   logic [DUR_W-1:0] count_q, count_d;
   logic [DUR_W-1:0] last_cnt;

   // A zero duration is treated as one tick long.
   assign last_cnt = (dur == '0) ? '0 : dur - DUR_W'(1);
   assign tc       = tick && !clr && (count_q == last_cnt);

   always_comb begin
      count_d = count_q;
      if (clr || tc)
         count_d = '0;
      else if (tick)
         count_d = count_q + DUR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/traffic_phase_seq.sv
// Traffic light phase sequencer with emergency all-red override.
// Build option: define TRAFFIC_PED_EN to make the walk phase request-driven.
module traffic_phase_seq
   import traffic_pkg::*;
#(
   parameter int T_NSG = 20,
   parameter int T_YEL = 3,
   parameter int T_CLR = 1,
   parameter int T_EWG = 20,
   parameter int T_PED = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic ped_req,
   input  logic emerg,
   output logic S1,
   output logic S2,
   output logic S3,
   output logic phase_done,
   output logic ped_ack
);

   phase_t           phase_q, phase_d;
   logic             done_q, done_d;
   logic             tc;
   logic             tmr_clr;
   logic [DUR_W-1:0] dur_sel;
   logic             pend_q;

   always_comb begin
      dur_sel = DUR_W'(1);
      case (phase_q)
         PH_NSG:          dur_sel = DUR_W'(T_NSG);
         PH_NSY, PH_EWY:  dur_sel = DUR_W'(T_YEL);
         PH_AR1, PH_AR2:  dur_sel = DUR_W'(T_CLR);
         PH_EWG:          dur_sel = DUR_W'(T_EWG);
         PH_PED:          dur_sel = DUR_W'(T_PED);
         default:         dur_sel = DUR_W'(1);
      endcase
   end

   // Ticks are ignored and the count held at zero while in or entering emergency.
   assign tmr_clr = emerg || (phase_q == PH_EMG);

   phase_timer u_timer (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .clr  (tmr_clr),
      .dur  (dur_sel),
      .tc   (tc)
   );

   always_comb begin
      phase_d = phase_q;
      if (emerg)
         phase_d = PH_EMG;
      else if (phase_q == PH_EMG)
         phase_d = PH_AR1;
      else if (tc) begin
         case (phase_q)
            PH_NSG:  phase_d = PH_NSY;
            PH_NSY:  phase_d = PH_AR1;
            PH_AR1:  phase_d = PH_EWG;
            PH_EWG:  phase_d = PH_EWY;
            PH_EWY:  phase_d = PH_AR2;
            PH_AR2:  phase_d = pend_q ? PH_PED : PH_NSG;
            PH_PED:  phase_d = PH_NSG;
            default: phase_d = PH_AR1;
         endcase
      end
      done_d = (phase_d != phase_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_AR1;
         done_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         done_q  <= done_d;
      end
   end

`ifdef TRAFFIC_PED_EN
   logic pend_d;
   logic ack_q, ack_d;
   logic enter_ped;

   assign enter_ped = (phase_d == PH_PED) && (phase_q != PH_PED);

   // Entering the walk phase serves the request; that clear beats a same-cycle set.
   always_comb begin
      pend_d = enter_ped ? 1'b0 : (pend_q | ped_req);
      ack_d  = enter_ped;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ack_q  <= ack_d;
      end
   end

   assign ped_ack = ack_q;
`else
   logic ped_req_unused;

   // Without the request feature the walk phase is part of every cycle.
   assign pend_q         = 1'b1;
   assign ped_req_unused = ped_req;
   assign ped_ack        = 1'b0;
`endif

   assign S1         = phase_q[0];
   assign S2         = phase_q[1];
   assign S3         = phase_q[2];
   assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Bench for traffic_phase_seq: default-timing instance plus a zero-yellow instance.
module tb_traffic_phase_seq;

`ifdef TRAFFIC_PED_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, tick, ped_req, emerg;
   logic [1:0] s1, s2, s3, done, ack;

   int checks   = 0;
   int failures = 0;
   int ack_seen = 0;

   // Reference model state, one slot per instance
   int mph[2], mcnt[2];
   bit mpend[2], mdone[2], mack[2];
   int mdur[2][8];
   bit mvalid = 1'b0;

   always #5 clk = ~clk;

   traffic_phase_seq u_dut (
      .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .emerg(emerg),
      .S1(s1[0]), .S2(s2[0]), .S3(s3[0]), .phase_done(done[0]), .ped_ack(ack[0])
   );

   traffic_phase_seq #(.T_YEL(0)) u_y0 (
      .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .emerg(emerg),
      .S1(s1[1]), .S2(s2[1]), .S3(s3[1]), .phase_done(done[1]), .ped_ack(ack[1])
   );

   function automatic int dut_ph(int i);
      return int'({s3[i], s2[i], s1[i]});
   endfunction

   function automatic int after_phase(int p, bit pend);
      if (p == 5) return (!PED_EN || pend) ? 6 : 0;
      if (p == 6) return 0;
      return p + 1;
   endfunction

   task automatic model_step(int i, bit r, bit t, bit p, bit e);
      int old, lim;
      bit np;
      if (r) begin
         mph[i] = 2; mcnt[i] = 0; mpend[i] = 0; mdone[i] = 0; mack[i] = 0;
         return;
      end
      old = mph[i];
      np  = PED_EN && (mpend[i] || p);
      lim = (mdur[i][old] < 1) ? 1 : mdur[i][old];
      if (e) begin
         mph[i] = 7; mcnt[i] = 0;
      end else if (old == 7) begin
         mph[i] = 2; mcnt[i] = 0;
      end else if (t) begin
         if (mcnt[i] + 1 >= lim) begin
            mph[i] = after_phase(old, mpend[i]); mcnt[i] = 0;
         end else
            mcnt[i] = mcnt[i] + 1;
      end
      mdone[i] = (mph[i] != old);
      mack[i]  = PED_EN && mph[i] == 6 && old != 6;
      mpend[i] = (mph[i] == 6 && old != 6) ? 1'b0 : np;
   endtask

   task automatic cyc(bit t, bit p, bit e, bit r);
      tick = t; ped_req = p; emerg = e; rst = r;
      @(posedge clk);
      model_step(0, r, t, p, e);
      model_step(1, r, t, p, e);
      if (r) mvalid = 1'b1;
      #1;
   endtask

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick_until(int target, int budget);
      int n = 0;
      while (dut_ph(0) != target && n < budget) begin
         cyc(1, 0, 0, 0);
         n++;
      end
      chk($sformatf("reach_phase_%0d", target), dut_ph(0), target);
   endtask

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (mvalid) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_phase[%0d]", i), dut_ph(i), mph[i]);
            chk($sformatf("model_done[%0d]", i), int'(done[i]), int'(mdone[i]));
            chk($sformatf("model_ack[%0d]", i), int'(ack[i]), int'(mack[i]));
         end
         if (ack[0] === 1'b1) ack_seen++;
      end
   end

   initial begin
      int n;
      mdur[0] = '{20, 3, 1, 20, 3, 1, 10, 1};
      mdur[1] = '{20, 0, 1, 20, 0, 1, 10, 1};
      tick = 0; ped_req = 0; emerg = 0; rst = 0;
      @(posedge clk); #1;

      cyc(0, 0, 0, 1);
      cyc(1, 1, 1, 1);
      chk("reset_phase", dut_ph(0), 2);
      chk("reset_done", int'(done[0]), 0);
      chk("reset_ack", int'(ack[0]), 0);

      // Clearance lasts one tick, EW-green twenty
      cyc(1, 0, 0, 0);
      chk("tick1_phase", dut_ph(0), 3);
      chk("tick1_done", int'(done[0]), 1);
      cyc(0, 0, 0, 0);
      chk("tick1_done_drop", int'(done[0]), 0);
      for (int k = 0; k < 19; k++) begin
         cyc(1, 0, 0, 0);
         cyc(0, 0, 0, 0);
      end
      chk("tick20_hold", dut_ph(0), 3);
      cyc(1, 0, 0, 0);
      chk("tick21_phase", dut_ph(0), 4);
      chk("tick21_done", int'(done[0]), 1);

      // Zero yellow duration behaves as one tick
      cyc(1, 0, 0, 0);
      chk("y0_yellow_1tick", dut_ph(1), 5);
      chk("yel_still", dut_ph(0), 4);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("yel_end", dut_ph(0), 5);
      ack_seen = 0;
      cyc(1, 0, 0, 0);
`ifdef TRAFFIC_PED_EN
      chk("no_req_skips_walk", dut_ph(0), 0);
`else
      chk("walk_every_loop", dut_ph(0), 6);
`endif
      tick_until(0, 40);
      chk("no_req_no_ack", ack_seen, 0);

      // Pedestrian request in NS-green
      cyc(0, 1, 0, 0);
      ack_seen = 0;
      tick_until(6, 80);
`ifdef TRAFFIC_PED_EN
      chk("ped_ack_once", ack_seen, 1);
`else
      chk("ped_ack_tied", ack_seen, 0);
`endif
      n = 0;
      while (dut_ph(0) == 6 && n < 30) begin
         cyc(1, 0, 0, 0);
         n++;
      end
      chk("walk_len", n, 10);

      // Emergency beats a coincident expiring tick in EW-green
      tick_until(3, 80);
      for (int k = 0; k < 19; k++) cyc(1, 0, 0, 0);
      chk("ewg_before_emerg", dut_ph(0), 3);
      cyc(1, 0, 1, 0);
      chk("emerg_entry", dut_ph(0), 7);
      chk("emerg_entry_done", int'(done[0]), 1);
      for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0);
      chk("emerg_hold", dut_ph(0), 7);
      chk("emerg_hold_done", int'(done[0]), 0);
      cyc(0, 0, 0, 0);
      chk("emerg_exit", dut_ph(0), 2);
      chk("emerg_exit_done", int'(done[0]), 1);
      cyc(1, 0, 0, 0);
      chk("emerg_exit_cnt0", dut_ph(0), 3);

      // Reset in the walk phase overrides emergency and request
      cyc(0, 1, 0, 0);
      tick_until(6, 80);
      cyc(1, 0, 0, 0);
      cyc(1, 1, 1, 1);
      chk("rst_walk_phase", dut_ph(0), 2);
      chk("rst_walk_done", int'(done[0]), 0);
      chk("rst_walk_ack", int'(ack[0]), 0);
      tick_until(5, 80);
      cyc(1, 0, 0, 0);
`ifdef TRAFFIC_PED_EN
      chk("rst_cleared_pending", dut_ph(0), 0);
`else
      chk("rst_walk_again", dut_ph(0), 6);
`endif
      for (int k = 0; k < 40; k++) cyc(1, k % 7 == 0, 0, 0);
      cyc(0, 0, 0, 0);

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
